// File: rtl/rv32im_pipe_cpu.sv
// Five-stage in-order RV32I + MUL integer pipeline. Fetch is external and the data port is stallable.
// There is no forwarding and no interlock, so software spaces dependent instructions apart.
module rv32im_pipe_cpu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] INSTRUCTION,
  input  logic [XLEN-1:0] READ_DATA,
  input  logic            BUSYWAIT,
  output logic            MEM_READ,
  output logic            MEM_WRITE,
  output logic [XLEN-1:0] MEM_WRITE_DATA,
  output logic [XLEN-1:0] MEM_ADDRESS
);

  localparam int unsigned RIDX = 5;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [2:0] F3_W  = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    alu_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sdata;
    logic [RIDX-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
    logic [RIDX-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [RIDX-1:0] rd;
    logic            reg_write;
    logic            mem_read;
  } mem_wb_t;

  logic [XLEN-1:0] INSTRUCTION_OUT;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic [XLEN-1:0] WRITE_DATA;
  logic [XLEN-1:0] regs [NREGS];

  id_ex_t  id_ex, dec;
  ex_mem_t ex_mem, ex_next;
  mem_wb_t mem_wb, wb_next;
  logic [XLEN-1:0] alu_res;
  logic            wb_we;
  logic            unused_pc;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RIDX-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s;

  assign opcode = INSTRUCTION_OUT[6:0];
  assign rd     = INSTRUCTION_OUT[11:7];
  assign funct3 = INSTRUCTION_OUT[14:12];
  assign rs1    = INSTRUCTION_OUT[19:15];
  assign rs2    = INSTRUCTION_OUT[24:20];
  assign funct7 = INSTRUCTION_OUT[31:25];
  assign imm_i  = {{(XLEN-12){INSTRUCTION_OUT[31]}}, INSTRUCTION_OUT[31:20]};
  assign imm_s  = {{(XLEN-12){INSTRUCTION_OUT[31]}}, INSTRUCTION_OUT[31:25], INSTRUCTION_OUT[11:7]};
  assign unused_pc = ^PC;

  // Register file reads: a same-cycle write to the addressed register is passed straight through.
  assign wb_we      = mem_wb.reg_write && (mem_wb.rd != '0) && !BUSYWAIT;
  assign WRITE_DATA = mem_wb.mem_read ? mem_wb.rdata : mem_wb.alu;
  assign DATA1      = (wb_we && mem_wb.rd == rs1) ? WRITE_DATA : regs[rs1];
  assign DATA2      = (wb_we && mem_wb.rd == rs2) ? WRITE_DATA : regs[rs2];

  // Decode; anything unrecognised leaves dec as a bubble.
  always_comb begin
    dec       = '0;
    dec.op    = ALU_ADD;
    dec.a     = DATA1;
    dec.b     = DATA2;
    dec.rd    = rd;
    case (opcode)
      OP_R: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.op = ALU_ADD;
          {7'h20, 3'b000}: dec.op = ALU_SUB;
          {7'h00, 3'b001}: dec.op = ALU_SLL;
          {7'h00, 3'b010}: dec.op = ALU_SLT;
          {7'h00, 3'b011}: dec.op = ALU_SLTU;
          {7'h00, 3'b100}: dec.op = ALU_XOR;
          {7'h00, 3'b101}: dec.op = ALU_SRL;
          {7'h20, 3'b101}: dec.op = ALU_SRA;
          {7'h00, 3'b110}: dec.op = ALU_OR;
          {7'h00, 3'b111}: dec.op = ALU_AND;
          {7'h01, 3'b000}: dec.op = ALU_MUL;
          default: begin
            dec.valid     = 1'b0;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_I: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.b         = imm_i;
        case (funct3)
          3'b000: dec.op = ALU_ADD;
          3'b010: dec.op = ALU_SLT;
          3'b011: dec.op = ALU_SLTU;
          3'b100: dec.op = ALU_XOR;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
          3'b001: begin
            dec.op        = ALU_SLL;
            dec.valid     = (funct7 == 7'h00);
            dec.reg_write = (funct7 == 7'h00);
          end
          default: begin
            dec.op        = funct7[5] ? ALU_SRA : ALU_SRL;
            dec.valid     = (funct7 == 7'h00) || (funct7 == 7'h20);
            dec.reg_write = dec.valid;
          end
        endcase
      end
      OP_LW: begin
        if (funct3 == F3_W) begin
          dec.valid     = 1'b1;
          dec.reg_write = 1'b1;
          dec.mem_read  = 1'b1;
          dec.b         = imm_i;
        end
      end
      OP_SW: begin
        if (funct3 == F3_W) begin
          dec.valid     = 1'b1;
          dec.mem_write = 1'b1;
          dec.b         = imm_s;
          dec.sdata     = DATA2;
        end
      end
      default: dec.valid = 1'b0;
    endcase
  end

  // Execute
  always_comb begin
    alu_res = '0;
    case (id_ex.op)
      ALU_ADD:  alu_res = id_ex.a + id_ex.b;
      ALU_SUB:  alu_res = id_ex.a - id_ex.b;
      ALU_SLL:  alu_res = id_ex.a << id_ex.b[4:0];
      ALU_SLT:  alu_res = XLEN'($signed(id_ex.a) < $signed(id_ex.b));
      ALU_SLTU: alu_res = XLEN'(id_ex.a < id_ex.b);
      ALU_XOR:  alu_res = id_ex.a ^ id_ex.b;
      ALU_SRL:  alu_res = id_ex.a >> id_ex.b[4:0];
      ALU_SRA:  alu_res = $signed(id_ex.a) >>> id_ex.b[4:0];
      ALU_OR:   alu_res = id_ex.a | id_ex.b;
      ALU_AND:  alu_res = id_ex.a & id_ex.b;
      ALU_MUL:  alu_res = id_ex.a * id_ex.b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    ex_next = '0;
    if (id_ex.valid) begin
      ex_next.alu       = alu_res;
      ex_next.sdata     = id_ex.sdata;
      ex_next.rd        = id_ex.rd;
      ex_next.reg_write = id_ex.reg_write;
      ex_next.mem_read  = id_ex.mem_read;
      ex_next.mem_write = id_ex.mem_write;
    end
  end

  always_comb begin
    wb_next           = '0;
    wb_next.alu       = ex_mem.alu;
    wb_next.rdata     = ex_mem.mem_read ? READ_DATA : '0;
    wb_next.rd        = ex_mem.rd;
    wb_next.reg_write = ex_mem.reg_write;
    wb_next.mem_read  = ex_mem.mem_read;
  end

  // Pipeline registers; the whole pipe freezes while memory is busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      INSTRUCTION_OUT <= '0;
      id_ex           <= '0;
      ex_mem          <= '0;
      mem_wb          <= '0;
    end else if (!BUSYWAIT) begin
      INSTRUCTION_OUT <= INSTRUCTION;
      id_ex           <= dec;
      ex_mem          <= ex_next;
      mem_wb          <= wb_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[mem_wb.rd] <= WRITE_DATA;
    end
  end

  assign MEM_READ       = ex_mem.mem_read;
  assign MEM_WRITE      = ex_mem.mem_write;
  assign MEM_ADDRESS    = ex_mem.alu;
  assign MEM_WRITE_DATA = ex_mem.sdata;

endmodule

// File: tb/tb_rv32im_pipe_cpu.sv
// Directed bench for rv32im_pipe_cpu: table of single-instruction vectors plus stall/store/reset sequences.
module tb_rv32im_pipe_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [31:0] read_data = '0;
  logic        busywait = 1'b0;
  logic        mem_read, mem_write;
  logic [31:0] mem_write_data, mem_address;

  rv32im_pipe_cpu dut (
    .CLK(clk), .RESET(rst_n), .PC(pc), .INSTRUCTION(instr), .READ_DATA(read_data),
    .BUSYWAIT(busywait), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .MEM_WRITE_DATA(mem_write_data), .MEM_ADDRESS(mem_address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    int          rd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    @(negedge clk);
    instr = ins;
    pc    = pc + 32'd4;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic add(input logic [31:0] ins, input int rd, input logic [31:0] exp, input string name);
    vec_t v;
    v.ins = ins; v.rd = rd; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] regs_or();
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.regs[i];
    return acc;
  endfunction

  initial begin
    logic [31:0] pre;
    logic        strobe;
    int          wcount;

    for (int i = 0; i < 32; i++) model[i] = '0;

    add(enc_i(12'd5,   5'd0, 3'b000, 5'd2),  2,  32'd5,        "addi_x2");
    add(enc_i(12'd7,   5'd0, 3'b000, 5'd3),  3,  32'd7,        "addi_x3");
    add(enc_r(7'h00, 5'd3, 5'd2, 3'b000, 5'd1),  1,  32'd12,   "add");
    add(enc_r(7'h00, 5'd3, 5'd2, 3'b110, 5'd4),  4,  32'd7,    "or");
    add(enc_r(7'h00, 5'd3, 5'd2, 3'b111, 5'd7),  7,  32'd5,    "and");
    add(enc_r(7'h00, 5'd3, 5'd2, 3'b100, 5'd10), 10, 32'd2,    "xor");
    add(enc_r(7'h20, 5'd3, 5'd2, 3'b000, 5'd11), 11, 32'hFFFFFFFE, "sub");
    add(enc_i(12'hFF8, 5'd0, 3'b000, 5'd5),  5,  32'hFFFFFFF8, "addi_neg");
    add(enc_i(12'h401, 5'd5, 3'b101, 5'd6),  6,  32'hFFFFFFFC, "srai");
    add(enc_i(12'h001, 5'd5, 3'b101, 5'd13), 13, 32'h7FFFFFFC, "srli");
    add(enc_r(7'h00, 5'd2, 5'd5, 3'b010, 5'd8),  8,  32'd1,    "slt");
    add(enc_r(7'h00, 5'd2, 5'd5, 3'b011, 5'd14), 14, 32'd0,    "sltu");
    add(enc_r(7'h01, 5'd3, 5'd2, 3'b000, 5'd9),  9,  32'd35,   "mul");
    add(enc_i(12'd9,   5'd0, 3'b000, 5'd0),  0,  32'd0,        "addi_x0");
    add(enc_r(7'h00, 5'd3, 5'd2, 3'b001, 5'd15), 15, 32'd640,  "sll");
    add(enc_i(12'hFF9, 5'd5, 3'b010, 5'd16), 16, 32'd1,        "slti");
    add(enc_i(12'hFFF, 5'd2, 3'b011, 5'd17), 17, 32'd1,        "sltiu");
    add(enc_i(12'hFFF, 5'd2, 3'b100, 5'd18), 18, 32'hFFFFFFFA, "xori");
    add(enc_i(12'd3,   5'd3, 3'b111, 5'd19), 19, 32'd3,        "andi");
    add(enc_i(12'd8,   5'd2, 3'b110, 5'd20), 20, 32'd13,       "ori");
    add(enc_r(7'h20, 5'd2, 5'd5, 3'b101, 5'd21), 21, 32'hFFFFFFFF, "sra");
    add(enc_r(7'h00, 5'd2, 5'd5, 3'b101, 5'd22), 22, 32'h07FFFFFF, "srl");
    add(enc_i(12'h01F, 5'd3, 3'b001, 5'd23), 23, 32'h80000000, "slli");
    add(enc_r(7'h01, 5'd3, 5'd2, 3'b001, 5'd24), 24, 32'd0,    "unsupported_mulh");
    add(enc_i(12'd33,  5'd0, 3'b000, 5'd26), 26, 32'd33,       "addi_33");
    add(enc_r(7'h00, 5'd26, 5'd2, 3'b001, 5'd27), 27, 32'd10,  "sll_shamt_wrap");
    add(enc_r(7'h01, 5'd11, 5'd11, 3'b000, 5'd25), 25, 32'd4,  "mul_wrap");

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("reset_mem_read", {31'b0, mem_read}, 32'd0);
    check("reset_mem_write", {31'b0, mem_write}, 32'd0);
    check("reset_mem_address", mem_address, 32'd0);
    check("reset_mem_wdata", mem_write_data, 32'd0);
    check("reset_regs", regs_or(), 32'd0);
    rst_n = 1'b1;
    strobe = 1'b0;
    repeat (5) begin
      issue(32'h0);
      strobe |= mem_read | mem_write;
    end
    check("nop_strobes", {31'b0, strobe}, 32'd0);
    check("nop_regs", regs_or(), 32'd0);

    // Table: each instruction followed by NOPs; result must appear exactly at edge k+4
    foreach (vecs[i]) begin
      issue(vecs[i].ins);
      strobe = 1'b0;
      repeat (4) begin
        issue(32'h0);
        strobe |= mem_read | mem_write;
      end
      pre = dut.regs[vecs[i].rd];
      check({vecs[i].name, "_before_k4"}, pre, model[vecs[i].rd]);
      if (vecs[i].rd != 0) model[vecs[i].rd] = vecs[i].exp;
      issue(32'h0);
      check(vecs[i].name, dut.regs[vecs[i].rd], vecs[i].exp);
      check({vecs[i].name, "_strobes"}, {31'b0, strobe}, 32'd0);
    end
    for (int r = 0; r < 32; r++) check($sformatf("regfile_x%0d", r), dut.regs[r], model[r]);

    // Store: SW x3,4(x2) visible for exactly one cycle
    issue(enc_sw(12'd4, 5'd3, 5'd2));
    wcount = 0;
    for (int j = 0; j < 6; j++) begin
      issue(32'h0);
      if (mem_write) wcount++;
      if (j == 2) begin
        check("sw_mem_write", {31'b0, mem_write}, 32'd1);
        check("sw_mem_read", {31'b0, mem_read}, 32'd0);
        check("sw_address", mem_address, 32'd9);
        check("sw_wdata", mem_write_data, 32'd7);
      end
    end
    check("sw_write_cycles", wcount, 32'd1);
    check("sw_wdata_idle", mem_write_data, 32'd0);

    // Load with a 3-cycle BUSYWAIT, younger ADDI x28 must slip by exactly 3 cycles
    issue(enc_lw(12'd0, 5'd2, 5'd12));
    issue(enc_i(12'd3, 5'd0, 3'b000, 5'd28));
    issue(32'h0);
    @(negedge clk);
    check("lw_mem_read", {31'b0, mem_read}, 32'd1);
    check("lw_address", mem_address, 32'd5);
    busywait  = 1'b1;
    read_data = 32'hDEADBEEF;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d_mem_read", s), {31'b0, mem_read}, 32'd1);
      check($sformatf("stall%0d_address", s), mem_address, 32'd5);
      check($sformatf("stall%0d_x12", s), dut.regs[12], 32'd0);
    end
    busywait  = 1'b0;
    read_data = 32'h0000000A;
    @(negedge clk);
    check("lw_release_read_drop", {31'b0, mem_read}, 32'd0);
    check("lw_x12_not_yet", dut.regs[12], 32'd0);
    read_data = 32'h0;
    @(negedge clk);
    check("lw_x12", dut.regs[12], 32'd10);
    check("addi_x28_delayed", dut.regs[28], 32'd0);
    @(negedge clk);
    check("addi_x28", dut.regs[28], 32'd3);
    check("x0_still_zero", dut.regs[0], 32'd0);

    // Reset asserted while a store sits in MEM
    issue(enc_sw(12'd8, 5'd3, 5'd2));
    issue(32'h0);
    issue(32'h0);
    @(negedge clk);
    check("sw2_mem_write", {31'b0, mem_write}, 32'd1);
    check("sw2_address", mem_address, 32'd13);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("async_rst_address", mem_address, 32'd0);
    check("async_rst_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wcount = 0;
    repeat (6) begin
      issue(32'h0);
      if (mem_write) wcount++;
    end
    check("no_store_reissue", wcount, 32'd0);
    check("regs_after_reset", regs_or(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv32im_pipe_cpu.md
Name: rv32im_pipe_cpu

Overview:
- Five-stage in-order RV32 integer pipeline: IF/ID, ID/EX, EX/MEM, MEM/WB registers, 32x32 register file, ALU with MUL.
- Instruction fetch is external: the environment drives PC and INSTRUCTION directly into the IF/ID register.
- Data memory is external, accessed through a read/write strobe interface with BUSYWAIT stall.

Parameters:
- XLEN, 32, datapath width (fixed; not intended to be overridden).
- NREGS, 32, architectural register count; x0 hardwired to zero.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- PC  input  32  address of the instruction presented this cycle.
- INSTRUCTION  input  32  instruction word; 32'h0 is treated as a NOP.
- READ_DATA  input  32  load data from memory, valid when BUSYWAIT=0.
- BUSYWAIT  input  1  memory busy; freezes the whole pipeline while 1.
- MEM_READ  output  1  load request from the MEM stage.
- MEM_WRITE  output  1  store request from the MEM stage.
- MEM_WRITE_DATA  output  32  store data (rs2 value).
- MEM_ADDRESS  output  32  effective address (ALU result).

Behaviour:
- Reset (RESET=0, asynchronous):
  - All pipeline registers are cleared to a bubble (valid=0, no reg write, no mem op).
  - All 32 registers are cleared to 0.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITE_DATA=0.
- Supported instructions:
  - R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (funct7 0000000/0100000); MUL (funct7 0000001, funct3 000, low 32 bits of product).
  - I-type ALU (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; immediate is sign-extended from 12 bits.
  - LW (opcode 0000011, funct3 010) and SW (opcode 0100011, funct3 010).
  - Any other encoding is a NOP.
- Pipeline timing: an instruction presented before rising edge k:
  - is captured in IF/ID at edge k;
  - is decoded and registers are read in cycle k..k+1, then captured in ID/EX at edge k+1;
  - has its ALU result captured in EX/MEM at edge k+2;
  - drives MEM_* outputs combinationally from EX/MEM during k+2..k+3;
  - is captured in MEM/WB at edge k+3;
  - writes the register file at edge k+4.
- The write-back value is exposed as internal net WRITE_DATA: load data for LW, ALU result otherwise.
- Hierarchical debug nets are required: INSTRUCTION_OUT (IF/ID instruction), DATA1 and DATA2 (rs1/rs2 read values).
- Register file:
  - Two combinational read ports and one synchronous write port.
  - A read of the register being written in the same cycle returns the new value (write-through).
  - Writes to x0 are ignored.
- No forwarding and no hazard interlock. A consumer must trail its producer by at least two intervening instructions; software/bench inserts NOPs. Results are undefined otherwise.
- Arithmetic:
  - Modulo 2^32, no overflow trap.
  - Shifts use the low 5 bits of the shift operand; SRA/SRAI sign-fill.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Memory:
  - MEM_READ=1 only for LW in MEM; MEM_WRITE=1 only for SW in MEM.
  - Both are never 1 simultaneously and are 0 for bubbles.
  - MEM_ADDRESS = rs1 + sign-extended offset.
  - MEM_WRITE_DATA = rs2, and is 0 when no store is in MEM.
- Stall: while BUSYWAIT=1, every pipeline register and the register file hold; MEM_* outputs stay stable. PC/INSTRUCTION presented during a stall are not captured. The bench must hold them until BUSYWAIT falls.
- Reset asserted mid-operation: in-flight instructions are discarded immediately and MEM strobes drop asynchronously.

Test Plan:
- Reset: hold RESET=0 for 2 cycles -> all MEM outputs 0, all registers 0. Release, feed INSTRUCTION=0 for 5 cycles -> no MEM strobes, registers unchanged.
- ALU ops: ADDI x2,x0,5; ADDI x3,x0,7; 2 NOPs; ADD x1,x2,x3; OR x4,x2,x3; AND x7,x2,x3; XOR x10,x2,x3; SUB x11,x2,x3 -> x1=12, x4=7, x7=5, x10=2, x11=32'hFFFFFFFE. Each write lands at edge k+4.
- Shifts/compares/MUL: ADDI x5,x0,-8; SRAI x6,x5,1 -> x6=32'hFFFFFFFC; SRLI -> 32'h7FFFFFFC; SLT x8,x5,x2 -> 1; SLTU -> 0; MUL x9,x2,x3 -> 35.
- Store: SW x3,4(x2) -> in its MEM cycle MEM_WRITE=1, MEM_READ=0, MEM_ADDRESS=9, MEM_WRITE_DATA=7, for exactly 1 cycle.
- Load with stall: LW x12,0(x2) with READ_DATA=32'h0000000A, BUSYWAIT=1 for 3 cycles then 0 -> MEM_READ=1, MEM_ADDRESS=5 held through the stall; x12=10 after release; younger instructions delayed by exactly 3 cycles.
- Edge cases: ADDI x0,x0,9 -> x0 stays 0. Assert RESET=0 while a SW is in MEM -> MEM_WRITE drops immediately and the store is never re-issued.
